// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes timer interrupt / ecall / mret at commit,
// stalls, writes mepc+mcause then mstatus via clint_* ports, flushes, redirects.
//
// Ports:
//  clk, rst_n (sync, active-low)
//  inst_valid_i/inst_pc_i/inst_ecall_i/inst_mret_i : commit stage
//  global_int_en_i/mtime_int_en_i/mtime_int_pend_i : MIE/MTIE/MTIP
//  csr_mtvec_i/csr_mepc_i/csr_mstatus_i            : current CSR values
//  mepc_*/mcause_*/mstatus_* wen+wdata             : CSR write ports
//  hold_o, flush_o, redirect_pc_o, int_ack_o       : pipeline control

module trap_ctrl #(
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [1:0] MPP_MODE    = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [63:0] inst_pc_i,
  input  logic        inst_ecall_i,
  input  logic        inst_mret_i,
  input  logic        global_int_en_i,
  input  logic        mtime_int_en_i,
  input  logic        mtime_int_pend_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  output logic        mepc_wen_o,
  output logic [63:0] mepc_wdata_o,
  output logic        mcause_wen_o,
  output logic [63:0] mcause_wdata_o,
  output logic        mstatus_wen_o,
  output logic [63:0] mstatus_wdata_o,
  output logic        hold_o,
  output logic        flush_o,
  output logic [63:0] redirect_pc_o,
  output logic        int_ack_o
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    MSTAT,
    MRET,
    JUMP
  } state_t;

  localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL = 64'd11;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic [63:0] tgt_q, tgt_d;

  logic        int_req;
  logic        sel_int;
  logic        sel_ecall;
  logic        sel_mret;
  logic [63:0] base;
  logic        vec;
  logic [63:0] trap_tgt;
  logic [63:0] mstat_trap;
  logic [63:0] mstat_mret;

  assign int_req = global_int_en_i
                 & mtime_int_en_i
                 & mtime_int_pend_i;

  // one-hot selects in priority order: interrupt > ecall > mret
  assign sel_int   = inst_valid_i & int_req;
  assign sel_ecall = inst_valid_i & ~int_req
                   & inst_ecall_i;
  assign sel_mret  = inst_valid_i & ~int_req
                   & ~inst_ecall_i & inst_mret_i;

  assign base = {csr_mtvec_i[63:2], 2'b00};
  assign vec  = VECTORED_EN
              & (csr_mtvec_i[1:0] == 2'b01)
              & cause_q[63];
  assign trap_tgt = vec
    ? base + {cause_q[61:0], 2'b00}
    : base;

  always_comb begin
    mstat_trap        = csr_mstatus_i;
    mstat_trap[7]     = csr_mstatus_i[3];
    mstat_trap[3]     = 1'b0;
    mstat_trap[12:11] = MPP_MODE;
  end

  always_comb begin
    mstat_mret        = csr_mstatus_i;
    mstat_mret[3]     = csr_mstatus_i[7];
    mstat_mret[7]     = 1'b1;
    mstat_mret[12:11] = MPP_MODE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cause_d         = cause_q;
    tgt_d           = tgt_q;
    mepc_wen_o      = 1'b0;
    mepc_wdata_o    = '0;
    mcause_wen_o    = 1'b0;
    mcause_wdata_o  = '0;
    mstatus_wen_o   = 1'b0;
    mstatus_wdata_o = '0;
    hold_o          = 1'b0;
    flush_o         = 1'b0;
    redirect_pc_o   = '0;
    int_ack_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          sel_int: begin
            hold_o  = 1'b1;
            pc_d    = inst_pc_i;
            cause_d = CAUSE_MTI;
            state_d = SAVE;
          end
          sel_ecall: begin
            hold_o  = 1'b1;
            pc_d    = inst_pc_i;
            cause_d = CAUSE_ECALL;
            state_d = SAVE;
          end
          sel_mret: begin
            hold_o  = 1'b1;
            state_d = MRET;
          end
          default: ;
        endcase
      end
      SAVE: begin
        hold_o         = 1'b1;
        mepc_wen_o     = 1'b1;
        mepc_wdata_o   = pc_q;
        mcause_wen_o   = 1'b1;
        mcause_wdata_o = cause_q;
        int_ack_o      = cause_q[63];
        state_d        = MSTAT;
      end
      MSTAT: begin
        hold_o          = 1'b1;
        mstatus_wen_o   = 1'b1;
        mstatus_wdata_o = mstat_trap;
        tgt_d           = trap_tgt;
        state_d         = JUMP;
      end
      MRET: begin
        hold_o          = 1'b1;
        mstatus_wen_o   = 1'b1;
        mstatus_wdata_o = mstat_mret;
        tgt_d           = csr_mepc_i;
        state_d         = JUMP;
      end
      JUMP: begin
        hold_o        = 1'b1;
        flush_o       = 1'b1;
        redirect_pc_o = tgt_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // reset asserted mid-sequence must not leak a partial CSR write
    if (!rst_n) begin
      mepc_wen_o      = 1'b0;
      mepc_wdata_o    = '0;
      mcause_wen_o    = 1'b0;
      mcause_wdata_o  = '0;
      mstatus_wen_o   = 1'b0;
      mstatus_wdata_o = '0;
      hold_o          = 1'b0;
      flush_o         = 1'b0;
      redirect_pc_o   = '0;
      int_ack_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: per-cycle expected outputs are queued
// with the stimulus and compared on the falling edge.

module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid_i;
  logic [63:0] inst_pc_i;
  logic        inst_ecall_i;
  logic        inst_mret_i;
  logic        global_int_en_i;
  logic        mtime_int_en_i;
  logic        mtime_int_pend_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        mepc_wen_o;
  logic [63:0] mepc_wdata_o;
  logic        mcause_wen_o;
  logic [63:0] mcause_wdata_o;
  logic        mstatus_wen_o;
  logic [63:0] mstatus_wdata_o;
  logic        hold_o;
  logic        flush_o;
  logic [63:0] redirect_pc_o;
  logic        int_ack_o;

  trap_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_valid_i     (inst_valid_i),
    .inst_pc_i        (inst_pc_i),
    .inst_ecall_i     (inst_ecall_i),
    .inst_mret_i      (inst_mret_i),
    .global_int_en_i  (global_int_en_i),
    .mtime_int_en_i   (mtime_int_en_i),
    .mtime_int_pend_i (mtime_int_pend_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .mepc_wen_o       (mepc_wen_o),
    .mepc_wdata_o     (mepc_wdata_o),
    .mcause_wen_o     (mcause_wen_o),
    .mcause_wdata_o   (mcause_wdata_o),
    .mstatus_wen_o    (mstatus_wen_o),
    .mstatus_wdata_o  (mstatus_wdata_o),
    .hold_o           (hold_o),
    .flush_o          (flush_o),
    .redirect_pc_o    (redirect_pc_o),
    .int_ack_o        (int_ack_o)
  );

  typedef struct {
    string       tag;
    logic        hold;
    logic        flush;
    logic [63:0] redir;
    logic        epc_we;
    logic [63:0] epc_wd;
    logic        cau_we;
    logic [63:0] cau_wd;
    logic        mst_we;
    logic [63:0] mst_wd;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".hold"}, 64'(hold_o), 64'(e.hold));
      chk({e.tag, ".flush"}, 64'(flush_o), 64'(e.flush));
      chk({e.tag, ".redir"}, redirect_pc_o, e.redir);
      chk({e.tag, ".epc_we"}, 64'(mepc_wen_o), 64'(e.epc_we));
      chk({e.tag, ".epc_wd"}, mepc_wdata_o, e.epc_wd);
      chk({e.tag, ".cau_we"}, 64'(mcause_wen_o), 64'(e.cau_we));
      chk({e.tag, ".cau_wd"}, mcause_wdata_o, e.cau_wd);
      chk({e.tag, ".mst_we"}, 64'(mstatus_wen_o), 64'(e.mst_we));
      chk({e.tag, ".mst_wd"}, mstatus_wdata_o, e.mst_wd);
      chk({e.tag, ".ack"}, 64'(int_ack_o), 64'(e.ack));
    end
  end

  function automatic exp_t idle(input string tag);
    exp_t e;
    e.tag = tag; e.hold = 0; e.flush = 0; e.redir = 0;
    e.epc_we = 0; e.epc_wd = 0; e.cau_we = 0; e.cau_wd = 0;
    e.mst_we = 0; e.mst_wd = 0; e.ack = 0;
    return e;
  endfunction

  function automatic exp_t det(input string tag);
    exp_t e;
    e = idle(tag);
    e.hold = 1;
    return e;
  endfunction

  function automatic exp_t save(input string tag,
                                input logic [63:0] pc,
                                input logic [63:0] cause,
                                input logic ack);
    exp_t e;
    e = det(tag);
    e.epc_we = 1; e.epc_wd = pc;
    e.cau_we = 1; e.cau_wd = cause;
    e.ack = ack;
    return e;
  endfunction

  function automatic exp_t mst(input string tag,
                               input logic [63:0] wd);
    exp_t e;
    e = det(tag);
    e.mst_we = 1; e.mst_wd = wd;
    return e;
  endfunction

  function automatic exp_t jmp(input string tag,
                               input logic [63:0] pc);
    exp_t e;
    e = det(tag);
    e.flush = 1; e.redir = pc;
    return e;
  endfunction

  task automatic tick(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_valid_i = 0;
    inst_ecall_i = 0;
    inst_mret_i  = 0;
  endtask

  task automatic commit(input logic [63:0] pc,
                        input logic ec,
                        input logic mr);
    inst_valid_i = 1;
    inst_pc_i    = pc;
    inst_ecall_i = ec;
    inst_mret_i  = mr;
  endtask

  initial begin
    rst_n = 0;
    quiet();
    inst_pc_i        = 0;
    global_int_en_i  = 0;
    mtime_int_en_i   = 0;
    mtime_int_pend_i = 0;
    csr_mtvec_i      = 0;
    csr_mepc_i       = 0;
    csr_mstatus_i    = 0;
    @(posedge clk);
    #1;
    tick(idle("rst0"));
    tick(idle("rst1"));
    rst_n = 1;
    tick(idle("idle"));

    // ecall, direct mode, extra mstatus bits must survive
    csr_mtvec_i   = 64'h8000_0100;
    csr_mstatus_i = 64'hA000_0000_0000_0008;
    commit(64'h8000_0010, 1, 0);
    tick(det("ec.det"));
    quiet();
    tick(save("ec.save", 64'h8000_0010, 64'd11, 0));
    tick(mst("ec.mst", 64'hA000_0000_0000_1880));
    tick(jmp("ec.jmp", 64'h8000_0100));
    tick(idle("ec.idle"));

    // timer interrupt + ecall same cycle, vectored mtvec
    csr_mtvec_i      = 64'h8000_0201;
    csr_mstatus_i    = 64'h8;
    global_int_en_i  = 1;
    mtime_int_en_i   = 1;
    mtime_int_pend_i = 1;
    commit(64'h8000_0040, 1, 0);
    tick(det("iv.det"));
    quiet();
    tick(save("iv.save", 64'h8000_0040,
              64'h8000_0000_0000_0007, 1));
    tick(mst("iv.mst", 64'h1880));
    tick(jmp("iv.jmp", 64'h8000_021C));

    // back-to-back at T+4, direct mode 00
    csr_mtvec_i = 64'h8000_0200;
    commit(64'h8000_0044, 0, 0);
    tick(det("id.det"));
    quiet();
    tick(save("id.save", 64'h8000_0044,
              64'h8000_0000_0000_0007, 1));
    tick(mst("id.mst", 64'h1880));
    tick(jmp("id.jmp", 64'h8000_0200));

    // reserved mode 11 falls back to direct
    csr_mtvec_i = 64'h8000_0203;
    commit(64'h8000_0048, 0, 0);
    tick(det("ir.det"));
    quiet();
    tick(save("ir.save", 64'h8000_0048,
              64'h8000_0000_0000_0007, 1));
    tick(mst("ir.mst", 64'h1880));
    tick(jmp("ir.jmp", 64'h8000_0200));

    // pending but MIE=0: no trap; no valid commit: no trap
    global_int_en_i = 0;
    commit(64'h8000_0050, 0, 0);
    tick(idle("mie0"));
    quiet();
    global_int_en_i = 1;
    tick(idle("nv0"));
    tick(idle("nv1"));
    commit(64'h8000_0054, 0, 0);
    tick(det("late.det"));
    quiet();
    global_int_en_i  = 0;
    mtime_int_pend_i = 0;
    tick(save("late.save", 64'h8000_0054,
              64'h8000_0000_0000_0007, 1));
    tick(mst("late.mst", 64'h1880));
    tick(jmp("late.jmp", 64'h8000_0200));

    // mret
    csr_mepc_i    = 64'h8000_0014;
    csr_mstatus_i = 64'h80;
    commit(64'h8000_0060, 0, 1);
    tick(det("mr.det"));
    quiet();
    tick(mst("mr.mst", 64'h1888));
    tick(jmp("mr.jmp", 64'h8000_0014));

    // ecall+mret same cycle: ecall wins; commit input ignored while busy
    csr_mtvec_i   = 64'h8000_0100;
    csr_mstatus_i = 64'h0;
    commit(64'h8000_0070, 1, 1);
    tick(det("em.det"));
    commit(64'h8000_0074, 1, 0);
    tick(save("em.save", 64'h8000_0070, 64'd11, 0));
    quiet();
    tick(mst("em.mst", 64'h1800));
    tick(jmp("em.jmp", 64'h8000_0100));
    tick(idle("em.idle"));

    // reset during MSTAT
    csr_mstatus_i = 64'h8;
    commit(64'h8000_0080, 1, 0);
    tick(det("rs.det"));
    quiet();
    tick(save("rs.save", 64'h8000_0080, 64'd11, 0));
    rst_n = 0;
    tick(idle("rs.mst"));
    rst_n = 1;
    tick(idle("rs.after"));
    tick(idle("rs.after2"));

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(posedge clk);
    chk("drain", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
